// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU control unit and its funct decoder:
//   ALU control codes, R-type funct opcodes, the main-decoder aluop
//   classes and the MUL sequencer state encoding.
//   Optional feature macro used by the importing files: ALU_CTRL_SHIFT_EN
//   (enables LSL/LSR decode).
package alu_ctrl_pkg;

  // 4-bit ALU control codes; wider control words zero-extend these.
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MOVZ  = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_LSL   = 4'b1000;
  localparam logic [3:0] ALU_LSR   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;

  // Instruction bits [31:21] for the supported R-type operations.
  localparam logic [10:0] FUNCT_ADD = 11'b10001011000;
  localparam logic [10:0] FUNCT_SUB = 11'b11001011000;
  localparam logic [10:0] FUNCT_AND = 11'b10001010000;
  localparam logic [10:0] FUNCT_ORR = 11'b10101010000;
  localparam logic [10:0] FUNCT_EOR = 11'b11001010000;
  localparam logic [10:0] FUNCT_LSL = 11'b11010011011;
  localparam logic [10:0] FUNCT_LSR = 11'b11010011010;
  localparam logic [10:0] FUNCT_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_MOVZ  = 2'b11
  } aluop_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_funct_dec.sv
// alu_funct_dec
//   Pure combinational decoder from main-decoder aluop and R-type funct
//   field to an ALU control code, plus MUL and illegal-opcode flags.
//   Shared with the single-cycle core.
//   Macro ALU_CTRL_SHIFT_EN: when defined LSL/LSR decode; otherwise their
//   funct values are treated as illegal.
// Ports:
//   funct      in  11      instruction bits [31:21]
//   aluop      in  2       ALU op class from main decoder
//   code       out CTRL_W  ALU control code, zero-extended
//   is_mul     out 1       decoded instruction is MUL
//   is_illegal out 1       R-type funct not recognised
module alu_funct_dec
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [10:0]       funct,
  input  logic [1:0]        aluop,
  output logic [CTRL_W-1:0] code,
  output logic              is_mul,
  output logic              is_illegal
);

  logic [3:0] code4;

  // Decode to a 4-bit code first, then zero-extend into the output word.
  always_comb begin
    code4      = ALU_AND;
    is_mul     = 1'b0;
    is_illegal = 1'b0;
    case (aluop_t'(aluop))
      ALUOP_MEM:  code4 = ALU_ADD;
      ALUOP_CBZ:  code4 = ALU_PASSB;
      ALUOP_MOVZ: code4 = ALU_MOVZ;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: code4 = ALU_ADD;
          FUNCT_SUB: code4 = ALU_SUB;
          FUNCT_AND: code4 = ALU_AND;
          FUNCT_ORR: code4 = ALU_ORR;
          FUNCT_EOR: code4 = ALU_EOR;
`ifdef ALU_CTRL_SHIFT_EN
          FUNCT_LSL: code4 = ALU_LSL;
          FUNCT_LSR: code4 = ALU_LSR;
`endif
          FUNCT_MUL: begin
            code4  = ALU_MUL;
            is_mul = 1'b1;
          end
          default: begin
            code4      = ALU_AND;
            is_illegal = 1'b1;
          end
        endcase
      end
      default: code4 = ALU_AND;
    endcase
  end

  always_comb begin
    code       = '0;
    code[3:0]  = code4;
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq
//   Registered ALU control unit at the ID/EX boundary. Decodes aluop/funct
//   into an ALU control word one cycle after acceptance and sequences a
//   fixed-latency busy window for MUL, stalling upstream meanwhile.
//   Macro ALU_CTRL_SHIFT_EN (via alu_funct_dec): enables LSL/LSR decode.
// Ports:
//   clk        in  1       system clock, rising edge
//   reset      in  1       synchronous, active-high reset
//   valid_i    in  1       decode stage presents a valid instruction
//   funct      in  11      instruction bits [31:21]
//   aluop      in  2       ALU op class from main decoder
//   alucontrol out CTRL_W  registered ALU control word
//   valid_o    out 1       alucontrol valid for EX this cycle
//   mul_busy   out 1       MUL in progress in EX
//   stall      out 1       hold IF/ID and ID/EX (combinational from state)
//   illegal    out 1       one-cycle pulse for an undecodable R-type
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [10:0]       funct,
  input  logic [1:0]        aluop,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              valid_o,
  output logic              mul_busy,
  output logic              stall,
  output logic              illegal
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [CTRL_W-1:0] dec_code;
  logic              dec_is_mul;
  logic              dec_is_illegal;
  logic              accept;

  alu_funct_dec #(.CTRL_W(CTRL_W)) u_dec (
    .funct      (funct),
    .aluop      (aluop),
    .code       (dec_code),
    .is_mul     (dec_is_mul),
    .is_illegal (dec_is_illegal)
  );

  assign stall  = (state == BUSY);
  assign accept = valid_i && !stall;

  // Single FSM: IDLE registers decoded instructions; BUSY holds the MUL
  // word in EX and counts down the remaining occupancy. The last MUL cycle
  // is spent back in IDLE so the held instruction enters on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      alucontrol <= '0;
      valid_o    <= 1'b0;
      mul_busy   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alucontrol <= dec_code;
            valid_o    <= 1'b1;
            illegal    <= dec_is_illegal;
            if (dec_is_mul && (MUL_LAT > 1)) begin
              state    <= BUSY;
              counter  <= CNT_W'(MUL_LAT - 1);
              mul_busy <= 1'b1;
            end else begin
              mul_busy <= 1'b0;
            end
          end else begin
            valid_o  <= 1'b0;
            illegal  <= 1'b0;
            mul_busy <= 1'b0;
          end
        end
        BUSY: begin
          illegal <= 1'b0;
          if (counter == CNT_W'(1)) begin
            state    <= IDLE;
            counter  <= '0;
            mul_busy <= 1'b0;
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq
//   Directed self-checking bench for alu_ctrl_seq. Three instances share
//   the input stimulus: MUL_LAT=4 (main), MUL_LAT=3 (back-to-back MUL) and
//   MUL_LAT=1 (single-cycle MUL). All are reset between phases.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic [10:0] funct;
  logic [1:0]  aluop;

  logic [3:0] ctl4, ctl3, ctl1;
  logic       vo4, vo3, vo1;
  logic       mb4, mb3, mb1;
  logic       st4, st3, st1;
  logic       il4, il3, il1;

  int tests_run = 0;
  int tests_failed = 0;

  alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(4)) dut4 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct(funct), .aluop(aluop),
    .alucontrol(ctl4), .valid_o(vo4), .mul_busy(mb4), .stall(st4), .illegal(il4)
  );

  alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct(funct), .aluop(aluop),
    .alucontrol(ctl3), .valid_o(vo3), .mul_busy(mb3), .stall(st3), .illegal(il3)
  );

  alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .funct(funct), .aluop(aluop),
    .alucontrol(ctl1), .valid_o(vo1), .mul_busy(mb1), .stall(st1), .illegal(il1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tickCycle();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and step one edge.
  task automatic applyStimulus(input logic v, input logic [10:0] f, input logic [1:0] a);
    valid_i = v;
    funct   = f;
    aluop   = a;
    tickCycle();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic resetAll(input int cycles);
    reset   = 1'b1;
    valid_i = 1'b0;
    for (int i = 0; i < cycles; i++) tickCycle();
    reset = 1'b0;
  endtask

  logic [3:0] lsl_code;
  logic       lsl_illegal;

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    funct   = '0;
    aluop   = 2'b00;
`ifdef ALU_CTRL_SHIFT_EN
    lsl_code    = 4'b1000;
    lsl_illegal = 1'b0;
`else
    lsl_code    = 4'b0000;
    lsl_illegal = 1'b1;
`endif
    resetAll(2);

    // Enter BUSY, then reset for 2 cycles mid-MUL.
    applyStimulus(1'b1, FUNCT_MUL, 2'b10);
    checkOutput("mul_enter_ctl", 32'(ctl4), 32'h a);
    checkOutput("mul_enter_stall", 32'(st4), 32'h1);
    checkOutput("mul_enter_busy", 32'(mb4), 32'h1);
    resetAll(2);
    checkOutput("rst_ctl", 32'(ctl4), 32'h0);
    checkOutput("rst_valid", 32'(vo4), 32'h0);
    checkOutput("rst_busy", 32'(mb4), 32'h0);
    checkOutput("rst_stall", 32'(st4), 32'h0);
    checkOutput("rst_illegal", 32'(il4), 32'h0);

    // R-type stream.
    applyStimulus(1'b1, FUNCT_ADD, 2'b10);
    checkOutput("add_ctl", 32'(ctl4), 32'h2);
    checkOutput("add_valid", 32'(vo4), 32'h1);
    checkOutput("add_stall", 32'(st4), 32'h0);
    applyStimulus(1'b1, FUNCT_SUB, 2'b10);
    checkOutput("sub_ctl", 32'(ctl4), 32'h6);
    checkOutput("sub_stall", 32'(st4), 32'h0);
    applyStimulus(1'b1, FUNCT_AND, 2'b10);
    checkOutput("and_ctl", 32'(ctl4), 32'h0);
    checkOutput("and_stall", 32'(st4), 32'h0);
    applyStimulus(1'b1, FUNCT_ORR, 2'b10);
    checkOutput("orr_ctl", 32'(ctl4), 32'h1);
    checkOutput("orr_stall", 32'(st4), 32'h0);
    applyStimulus(1'b1, FUNCT_EOR, 2'b10);
    checkOutput("eor_ctl", 32'(ctl4), 32'h4);
    checkOutput("eor_illegal", 32'(il4), 32'h0);

    // Bubble keeps the previous control word.
    applyStimulus(1'b0, FUNCT_SUB, 2'b10);
    checkOutput("bubble_valid", 32'(vo4), 32'h0);
    checkOutput("bubble_ctl_hold", 32'(ctl4), 32'h4);

    // Illegal funct pulses for exactly one cycle.
    applyStimulus(1'b1, 11'b11111111111, 2'b10);
    checkOutput("illegal_ctl", 32'(ctl4), 32'h0);
    checkOutput("illegal_pulse", 32'(il4), 32'h1);
    checkOutput("illegal_valid", 32'(vo4), 32'h1);
    applyStimulus(1'b0, 11'b0, 2'b00);
    checkOutput("illegal_drop", 32'(il4), 32'h0);

    // LSL: decodes or is illegal depending on the shift build option.
    applyStimulus(1'b1, FUNCT_LSL, 2'b10);
    checkOutput("lsl_ctl", 32'(ctl4), 32'(lsl_code));
    checkOutput("lsl_illegal", 32'(il4), 32'(lsl_illegal));
    applyStimulus(1'b0, 11'b0, 2'b00);
    checkOutput("lsl_illegal_drop", 32'(il4), 32'h0);

    // Non R-type classes ignore funct.
    applyStimulus(1'b1, 11'b11111111111, 2'b00);
    checkOutput("aluop00_ctl", 32'(ctl4), 32'h2);
    applyStimulus(1'b1, FUNCT_SUB, 2'b01);
    checkOutput("aluop01_ctl", 32'(ctl4), 32'h7);
    applyStimulus(1'b1, 11'b11111111111, 2'b11);
    checkOutput("aluop11_ctl", 32'(ctl4), 32'h3);
    checkOutput("aluop11_illegal", 32'(il4), 32'h0);

    // MUL_LAT=4 with ADD held upstream.
    resetAll(1);
    applyStimulus(1'b1, FUNCT_MUL, 2'b10);
    funct = FUNCT_ADD;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mul4_ctl_c%0d", i), 32'(ctl4), 32'h a);
      checkOutput($sformatf("mul4_stall_c%0d", i), 32'(st4), (i < 3) ? 32'h1 : 32'h0);
      checkOutput($sformatf("mul4_valid_c%0d", i), 32'(vo4), 32'h1);
      tickCycle();
    end
    checkOutput("mul4_then_add_ctl", 32'(ctl4), 32'h2);
    checkOutput("mul4_then_add_stall", 32'(st4), 32'h0);

    // Back-to-back MULs with MUL_LAT=3.
    resetAll(1);
    applyStimulus(1'b1, FUNCT_MUL, 2'b10);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("mul3_ctl_c%0d", k), 32'(ctl3), 32'h a);
      checkOutput($sformatf("mul3_stall_c%0d", k), 32'(st3), (k % 3 == 2) ? 32'h0 : 32'h1);
      if (k == 3) valid_i = 1'b0;
      if (k < 5) tickCycle();
    end
    tickCycle();
    checkOutput("mul3_after_valid", 32'(vo3), 32'h0);
    checkOutput("mul3_after_ctl_hold", 32'(ctl3), 32'h a);

    // MUL_LAT=1: MUL is single-cycle.
    resetAll(1);
    applyStimulus(1'b1, FUNCT_MUL, 2'b10);
    checkOutput("mul1_ctl", 32'(ctl1), 32'h a);
    checkOutput("mul1_stall", 32'(st1), 32'h0);
    applyStimulus(1'b1, FUNCT_SUB, 2'b10);
    checkOutput("mul1_sub_ctl", 32'(ctl1), 32'h6);
    checkOutput("mul1_sub_stall", 32'(st1), 32'h0);
    applyStimulus(1'b0, 11'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
